// File: rtl/ilb_pkg.sv
// ilb_pkg: shared sizes and FSM state encoding for the instruction line buffer
package ilb_pkg;
  localparam int ILB_DEPTH = 32;
  localparam int ILB_AW = 5;
  localparam int ILB_IW = 32;
  typedef enum logic [2:0] {ST_EMPTY, ST_LOADING, ST_READY, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/instr_line_buffer_if.sv
// instr_line_buffer_if: program-load handshake channel into the line buffer
interface instr_line_buffer_if #(parameter int IW = ilb_pkg::ILB_IW);
  logic          load_valid;
  logic          load_ready;
  logic          load_last;
  logic [IW-1:0] load_data;
  modport master (output load_valid, load_data, load_last, input load_ready);
  modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/ilb_mem_2r1w.sv
// ilb_mem_2r1w: instruction array, one synchronous write port, two async read ports
module ilb_mem_2r1w #(
  parameter int DEPTH = ilb_pkg::ILB_DEPTH,
  parameter int AW = ilb_pkg::ILB_AW,
  parameter int IW = ilb_pkg::ILB_IW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [IW-1:0] wd,
  input  logic [AW-1:0] ra0,
  input  logic [AW-1:0] ra1,
  output logic [IW-1:0] rd0,
  output logic [IW-1:0] rd1
);
  logic [IW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
endmodule

// File: rtl/instr_line_buffer.sv
// instr_line_buffer: holds the loaded program and returns the PC/PC+1 pair one cycle after fetch presents PC
module instr_line_buffer
  import ilb_pkg::*;
#(
  parameter int DEPTH = ILB_DEPTH,
  parameter int AW = ILB_AW,
  parameter int IW = ILB_IW
) (
  input  logic                clk,
  input  logic                reset,
  instr_line_buffer_if.slave  ld,
  input  logic                start,
  input  logic [AW-1:0]       PC,
  input  logic                hold,
  input  logic                flush,
  output logic                active,
  output logic [IW-1:0]       instr0,
  output logic [IW-1:0]       instr1,
  output logic                valid0,
  output logic                valid1,
  output logic [AW:0]         prog_len,
  output logic                load_err
);
  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wa;
  logic [AW-1:0] pc1;
  logic [AW:0]   pc_ext;
  logic [IW-1:0] rd0, rd1;
  logic          can_load, xfer, last_slot, past_end, in_prog1;
  // In DONE a start takes priority, so the beat is refused rather than lost
  assign can_load  = (state == ST_EMPTY) || (state == ST_LOADING) || (state == ST_DONE && !start);
  assign ld.load_ready = reset && can_load;
  assign xfer      = ld.load_valid && ld.load_ready;
  assign wa        = (state == ST_LOADING) ? wr_ptr : '0;
  assign last_slot = (state == ST_LOADING) && (wr_ptr == AW'(DEPTH - 1));
  assign pc1       = PC + AW'(1);
  assign pc_ext    = {1'b0, PC};
  assign past_end  = pc_ext >= prog_len;
  assign in_prog1  = (pc_ext + (AW+1)'(1)) < prog_len;
  ilb_mem_2r1w #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_mem (
    .clk(clk), .we(xfer), .wa(wa), .wd(ld.load_data),
    .ra0(PC), .ra1(pc1), .rd0(rd0), .rd1(rd1)
  );
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_EMPTY;
      wr_ptr   <= '0;
      prog_len <= '0;
      active   <= 1'b0;
      instr0   <= '0;
      instr1   <= '0;
      valid0   <= 1'b0;
      valid1   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      if (xfer) begin
        wr_ptr   <= wa + AW'(1);
        prog_len <= (state == ST_LOADING) ? prog_len + (AW+1)'(1) : (AW+1)'(1);
        load_err <= last_slot && !ld.load_last;
        state    <= (ld.load_last || last_slot) ? ST_READY : ST_LOADING;
      end
      if ((state == ST_READY || state == ST_DONE) && start) begin
        state  <= ST_RUN;
        active <= 1'b1;
      end
      if (state == ST_RUN && !hold) begin
        instr0 <= rd0;
        instr1 <= rd1;
        valid0 <= !past_end;
        valid1 <= in_prog1;
        if (past_end) begin
          state  <= ST_DONE;
          active <= 1'b0;
        end
      end
      if (flush) begin
        valid0 <= 1'b0;
        valid1 <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_line_buffer.sv
// tb_instr_line_buffer: randomized self-checking bench against a program-array reference model
module tb_instr_line_buffer;
  import ilb_pkg::*;
  localparam int D = ILB_DEPTH;
  localparam int AW = ILB_AW;
  localparam int IW = ILB_IW;
  logic clk = 0, reset = 0, start = 0, hold = 0, flush = 0;
  logic [AW-1:0] PC = '0;
  logic active, valid0, valid1, load_err;
  logic [IW-1:0] instr0, instr1;
  logic [AW:0] prog_len;
  instr_line_buffer_if #(.IW(IW)) ld ();
  instr_line_buffer dut (
    .clk(clk), .reset(reset), .ld(ld), .start(start), .PC(PC), .hold(hold), .flush(flush),
    .active(active), .instr0(instr0), .instr1(instr1), .valid0(valid0), .valid1(valid1),
    .prog_len(prog_len), .load_err(load_err)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [IW-1:0] m_mem [D];
  bit m_written [D];
  int m_len = 0;
  bit m_err = 0;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 0;
    #1;
    checks++; if (ld.load_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b want 0", ld.load_ready); end
    step;
    reset = 1;
    m_len = 0; m_err = 0;
    #1;
    checks++; if (prog_len !== '0) begin errors++; $display("FAIL reset_prog_len got %0d want 0", prog_len); end
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
    checks++; if ({valid0, valid1} !== 2'b00) begin errors++; $display("FAIL reset_valid got %b%b want 00", valid0, valid1); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_load_err got %b want 0", load_err); end
    checks++; if (instr0 !== '0 || instr1 !== '0) begin errors++; $display("FAIL reset_instr got %h %h want 0 0", instr0, instr1); end
    checks++; if (ld.load_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", ld.load_ready); end
  endtask

  task automatic load(input int n, input bit with_last, input bit rnd, input logic [IW-1:0] base);
    for (int i = 0; i < n; i++) begin
      ld.load_valid = 1;
      ld.load_data = rnd ? IW'($urandom) : base + IW'(i);
      ld.load_last = with_last && (i == n - 1);
      #1;
      checks++; if (ld.load_ready !== 1'b1) begin errors++; $display("FAIL load_ready beat %0d got %b want 1", i, ld.load_ready); end
      m_mem[i] = ld.load_data;
      m_written[i] = 1;
      step;
    end
    ld.load_valid = 0; ld.load_last = 0;
    m_len = n;
    m_err = (n == D) && !with_last;
    checks++; if (prog_len !== (AW+1)'(m_len)) begin errors++; $display("FAIL load_prog_len got %0d want %0d", prog_len, m_len); end
    checks++; if (load_err !== m_err) begin errors++; $display("FAIL load_err got %b want %b", load_err, m_err); end
    checks++; if (ld.load_ready !== 1'b0 || active !== 1'b0) begin errors++; $display("FAIL load_ready_state got ready=%b active=%b want 0 0", ld.load_ready, active); end
  endtask

  task automatic go;
    start = 1;
    step;
    start = 0;
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL start_active got %b want 1", active); end
  endtask

  task automatic run_pc(input int pc, output bit done);
    bit ev0, ev1;
    PC = AW'(pc);
    step;
    ev0 = pc < m_len;
    ev1 = pc + 1 < m_len;
    done = pc >= m_len;
    checks++; if ({valid0, valid1} !== {ev0, ev1}) begin errors++; $display("FAIL run_valid pc=%0d got %b%b want %b%b", pc, valid0, valid1, ev0, ev1); end
    checks++; if (active !== !done) begin errors++; $display("FAIL run_active pc=%0d got %b want %b", pc, active, !done); end
    if (!done) begin
      checks++; if (instr0 !== m_mem[pc]) begin errors++; $display("FAIL run_instr0 pc=%0d got %h want %h", pc, instr0, m_mem[pc]); end
      if (m_written[(pc + 1) % D]) begin
        checks++; if (instr1 !== m_mem[(pc + 1) % D]) begin errors++; $display("FAIL run_instr1 pc=%0d got %h want %h", pc, instr1, m_mem[(pc + 1) % D]); end
      end
    end else begin
      checks++; if (ld.load_ready !== 1'b1) begin errors++; $display("FAIL done_ready got %b want 1", ld.load_ready); end
    end
  endtask

  task automatic test_reset;
    do_reset;
    start = 1;
    step;
    start = 0;
    checks++; if (active !== 1'b0 || ld.load_ready !== 1'b1) begin errors++; $display("FAIL start_in_empty got active=%b ready=%b want 0 1", active, ld.load_ready); end
  endtask

  task automatic test_load_run;
    bit done;
    load(6, 1, 0, 32'hA0);
    go;
    for (int pc = 0; pc <= 6; pc += 2) run_pc(pc, done);
    checks++; if (!done) begin errors++; $display("FAIL load_run_done got 0 want 1"); end
  endtask

  task automatic test_start_wins;
    bit done;
    start = 1; ld.load_valid = 1; ld.load_data = 32'hDEAD; ld.load_last = 1;
    step;
    start = 0; ld.load_valid = 0; ld.load_last = 0;
    checks++; if (active !== 1'b1 || prog_len !== (AW+1)'(6)) begin errors++; $display("FAIL start_wins got active=%b len=%0d want 1 6", active, prog_len); end
    run_pc(0, done);
    run_pc(6, done);
  endtask

  task automatic test_boundary;
    bit done;
    load(5, 1, 1, 0);
    go;
    run_pc(4, done);
    run_pc(5, done);
    load(32, 1, 1, 0);
    go;
    run_pc(31, done);
    run_pc(30, done);
    do_reset;
  endtask

  task automatic test_overflow;
    load(32, 0, 1, 0);
    ld.load_valid = 1; ld.load_data = 32'h33;
    #1;
    checks++; if (ld.load_ready !== 1'b0) begin errors++; $display("FAIL beat33_ready got %b want 0", ld.load_ready); end
    step;
    ld.load_valid = 0;
    checks++; if (prog_len !== (AW+1)'(32) || load_err !== 1'b1) begin errors++; $display("FAIL overflow_hold got len=%0d err=%b want 32 1", prog_len, load_err); end
    do_reset;
  endtask

  task automatic test_hold_flush;
    bit done;
    load(8, 1, 1, 0);
    go;
    run_pc(2, done);
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      PC = AW'($urandom);
      step;
      checks++; if (instr0 !== m_mem[2] || instr1 !== m_mem[3] || {valid0, valid1} !== 2'b11) begin errors++; $display("FAIL hold_freeze got %h %h %b%b want %h %h 11", instr0, instr1, valid0, valid1, m_mem[2], m_mem[3]); end
    end
    PC = AW'(31);
    step;
    checks++; if (active !== 1'b1) begin errors++; $display("FAIL hold_no_advance got %b want 1", active); end
    flush = 1;
    step;
    checks++; if ({valid0, valid1} !== 2'b00 || instr0 !== m_mem[2]) begin errors++; $display("FAIL hold_flush got %b%b %h want 00 %h", valid0, valid1, instr0, m_mem[2]); end
    hold = 0;
    PC = 0;
    step;
    flush = 0;
    checks++; if ({valid0, valid1} !== 2'b00 || instr0 !== m_mem[0] || active !== 1'b1) begin errors++; $display("FAIL flush_only got %b%b %h act=%b want 00 %h 1", valid0, valid1, instr0, active, m_mem[0]); end
    run_pc(4, done);
    run_pc(8, done);
  endtask

  task automatic test_random;
    bit done;
    int pc, n;
    for (int p = 0; p < 6; p++) begin
      load($urandom_range(1, D - 1), 1, 1, 0);
      go;
      pc = 0; n = 0; done = 0;
      while (!done && n < 64) begin
        run_pc(pc, done);
        pc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, D - 1) : pc + 2;
        if (pc >= D) pc = D - 1;
        if (n > 40) pc = m_len;
        n++;
      end
      checks++; if (!done) begin errors++; $display("FAIL random_timeout prog %0d got running want done", p); end
    end
  endtask

  task automatic test_reset_mid;
    bit done;
    ld.load_valid = 1; ld.load_last = 0;
    for (int i = 0; i < 2; i++) begin ld.load_data = IW'($urandom); step; end
    do_reset;
    ld.load_valid = 0;
    load(4, 1, 1, 0);
    go;
    run_pc(0, done);
    do_reset;
  endtask

  initial begin
    ld.load_valid = 0; ld.load_last = 0; ld.load_data = '0;
    for (int i = 0; i < D; i++) m_written[i] = 0;
    step;
    test_reset;
    test_load_run;
    test_start_wins;
    test_boundary;
    test_overflow;
    test_hold_flush;
    test_random;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
